inst_cache_ctrl: RTL

INST_CACHE_CTRL -- requirements
Module: inst_cache_ctrl

---
 rtl/inst_cache_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/inst_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_cache_ctrl
// Description : Direct-mapped, read-only instruction cache controller. Tag and
//               valid arrays live here; line data lives in an external SRAM
//               with asynchronous read. Misses fetch a whole block from DRAM
//               and write it to the SRAM in a single FILL cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_cache_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int INDEX_W     = 4,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cpu_req,
    input  logic [ADDR_W-1:0]             cpu_addr,
    output logic                          cpu_ready,
    output logic [WORD_W-1:0]             cpu_inst,
    input  logic                          flush,
    output logic                          sram_we,
    output logic [INDEX_W-1:0]            sram_index,
    output logic [WORD_W*BLOCK_WORDS-1:0] sram_wdata,
    input  logic [WORD_W*BLOCK_WORDS-1:0] sram_rdata,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic [WORD_W*BLOCK_WORDS-1:0] mem_rdata,
    output logic [15:0]                   miss_count
);

    localparam int c_OFF_W  = $clog2(BLOCK_WORDS);
    localparam int c_LSB_W  = 2 + c_OFF_W;
    localparam int c_TAG_W  = ADDR_W - c_LSB_W - INDEX_W;
    localparam int c_LINES  = 1 << INDEX_W;
    localparam int c_LINE_W = WORD_W * BLOCK_WORDS;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MISS = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;

    logic [1:0]          r_state;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_sram_we;
    logic [INDEX_W-1:0]  r_fill_index;
    logic [c_TAG_W-1:0]  r_fill_tag;
    logic [c_LINE_W-1:0] r_block;
    logic [15:0]         r_miss_count;

    logic [c_LINES-1:0]  r_valid;
    logic [c_TAG_W-1:0]  r_tag [c_LINES];

    logic [c_OFF_W-1:0]  w_word;
    logic [INDEX_W-1:0]  w_index;
    logic [c_TAG_W-1:0]  w_tag;
    logic [1:0]          w_unused_byte_ofs;
    logic                w_hit;
    logic [WORD_W-1:0]   w_words [BLOCK_WORDS];

    // Fetch address fields; the byte offset never matters for word fetches
    assign w_word            = cpu_addr[2 +: c_OFF_W];
    assign w_index           = cpu_addr[c_LSB_W +: INDEX_W];
    assign w_tag             = cpu_addr[ADDR_W-1 -: c_TAG_W];
    assign w_unused_byte_ofs = cpu_addr[1:0];

    // Unpack the SRAM line into words for the word-offset mux
    for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_words
        assign w_words[g] = sram_rdata[g*WORD_W +: WORD_W];
    end

    // A hit is only recognised in IDLE so MISS/FILL never return data
    assign w_hit = (r_state == c_IDLE) && cpu_req && r_valid[w_index] &&
                   (r_tag[w_index] == w_tag);

    assign cpu_ready  = w_hit;
    assign cpu_inst   = w_hit ? w_words[w_word] : '0;
    assign sram_index = (r_state == c_IDLE) ? w_index : r_fill_index;
    assign sram_we    = r_sram_we;
    assign sram_wdata = r_block;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign miss_count = r_miss_count;

    // Miss/refill sequencer with registered DRAM request and SRAM write strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_sram_we    <= 1'b0;
            r_fill_index <= '0;
            r_fill_tag   <= '0;
            r_block      <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_sram_we <= 1'b0;
                    if (cpu_req && !w_hit) begin
                        r_state      <= c_MISS;
                        r_mem_req    <= 1'b1;
                        r_mem_addr   <= {w_tag, w_index, {c_LSB_W{1'b0}}};
                        r_fill_index <= w_index;
                        r_fill_tag   <= w_tag;
                        r_miss_count <= r_miss_count + 16'd1;
                    end
                end
                c_MISS: begin
                    // The miss runs to completion even if cpu_req drops
                    if (mem_ready) begin
                        r_state   <= c_FILL;
                        r_mem_req <= 1'b0;
                        r_block   <= mem_rdata;
                        r_sram_we <= 1'b1;
                    end
                end
                c_FILL: begin
                    r_state   <= c_IDLE;
                    r_sram_we <= 1'b0;
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_mem_req <= 1'b0;
                    r_sram_we <= 1'b0;
                end
            endcase
        end
    end

    // Tag/valid arrays: FILL installs the line, flush wins over the install
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < c_LINES; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (r_state == c_FILL) begin
                r_tag[r_fill_index]   <= r_fill_tag;
                r_valid[r_fill_index] <= 1'b1;
            end
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

endmodule
`default_nettype wire
